rr_output_arbiter: RTL and testbench
====================================

Name: rr_output_arbiter

Overview:
Per-output-port packet arbiter for the mesh router. One instance per output port (N, S, E, W, L). It shares that output between the five input ports using round-robin priority and holds a wormhole lock from head flit to tail flit. It drives the crossbar select, the output-port send enable and the input-FIFO pop (remove) strobes. Credit/full backpressure comes from the output port.

Parameters:
NUM_REQ, 5, number of requesters; index 0=N, 1=S, 2=E, 3=W, 4=L.
REQ_MASK, 5'b11111, bit i=0 means requester i is absent (edge routers) and its req/tail are ignored.
WDOG_CYCLES, 16, stall limit for the watchdog; used only when RR_ARB_WDOG_EN is defined.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-low reset.
req_i  in  NUM_REQ  requester i has a flit at its FIFO head destined for this output.
tail_i  in  NUM_REQ  the head flit of requester i is the last flit of its packet.
port_full_i  in  1  output port has no credit and cannot accept a flit this cycle.
port_select_o  out  3  crossbar select: 0..4 = requester index, 3'd7 = none.
port_enable_o  out  1  write current crossbar flit into the output port.
port_remove_o  out  NUM_REQ  one-hot pop of the granted input FIFO.
busy_o  out  1  a packet lock is held.
wdog_o  out  1  one-cycle pulse when the watchdog releases a lock; tied 0 when the feature is off.

Behaviour:
- Effective request: ereq = req_i & REQ_MASK. Effective tail: etail = tail_i & REQ_MASK.
- Registered state: state {IDLE, LOCKED}, gnt_id[2:0], rr_ptr[2:0] (last served index).
- Reset (rst=0 at a clk edge): state=IDLE, gnt_id=0, rr_ptr=NUM_REQ-1, stall counter=0. Outputs during and after reset until a grant: port_select_o=7, port_enable_o=0, port_remove_o=0, busy_o=0, wdog_o=0.
- Reset asserted mid-packet drops the lock immediately. There is no partial-packet recovery.
- IDLE:
  - If ereq != 0, pick the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Next cycle: gnt_id=winner, state=LOCKED.
  - No flit moves in IDLE; arbitration costs exactly 1 cycle.
  - port_full_i does not block arbitration.
- LOCKED:
  - port_select_o=gnt_id and busy_o=1, both driven from registers.
  - Transfer condition, combinational: xfer = ereq[gnt_id] & ~port_full_i.
  - When xfer: port_enable_o=1 and port_remove_o=(1<<gnt_id) in the same cycle; otherwise both are 0.
  - xfer & etail[gnt_id]: next state=IDLE, rr_ptr=gnt_id.
  - Single-flit packet: head=tail, so a 1-flit packet occupies 1 LOCKED cycle.
  - Requests from other ports while LOCKED are ignored.
  - Holder's req drops mid-packet (bubble): stay LOCKED, no transfer.
  - port_full_i=1: stay LOCKED, no transfer, no pop.
- Throughput: back-to-back packets from different requesters have 1 idle cycle between the tail of one and the head of the next. Within a packet, 1 flit/cycle while credit exists.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 packets.
- A masked requester never receives a grant, even if its req_i=1.
- rr_ptr changes only on tail transfer (or watchdog release).

Optional Feature:
Macro: RR_ARB_WDOG_EN.
- Defined:
  - A 5-bit stall counter increments each LOCKED cycle where ereq[gnt_id]=0; it does not count port_full_i stalls.
  - It clears on any xfer and on entry to LOCKED.
  - When the counter reaches WDOG_CYCLES: state=IDLE, rr_ptr=gnt_id, wdog_o pulses high for 1 cycle, no pop.
- Undefined: no counter exists; wdog_o=0 constant; a lock is held indefinitely until tail.

Test Plan:
1. Reset then req_i=5'b00001, tail_i=5'b00001, full=0 -> cycle 1: select=7, enable=0. Cycle 2: select=0, enable=1, remove=5'b00001. Cycle 3: IDLE, select=7.
2. All five ports request continuously with 1-flit packets -> grant order 0,1,2,3,4,0. Each grant gives one enable pulse every 2 cycles.
3. Port 3 sends a 4-flit packet (tail on flit 4) while port 1 requests; port_full_i=1 for 2 cycles after flit 2 -> exactly 4 enable pulses, none while full; port 1 granted only after the tail; select stays 3 throughout.
4. REQ_MASK=5'b11011, req_i=5'b00100 -> no grant, select stays 7, remove=0 forever.
5. rst driven low while LOCKED mid-packet -> next cycle select=7, busy=0, enable=0; after release, port 0 wins first.
6. With RR_ARB_WDOG_EN and WDOG_CYCLES=16: port 2 sends head with tail=0, then req drops -> after 16 cycles wdog_o pulses for 1 cycle, busy=0, and waiting port 3 is granted next. Without the macro, busy stays 1.

Source files
------------

// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter
// -----------------------------------------------------------------------------
// Per-output-port wormhole arbiter for the mesh router. There is one instance
// per output port. It shares the output between the N, S, E, W and L input
// FIFOs in round-robin order. A grant is held from the head flit to the tail
// flit of a packet.
//
// Optional feature: define RR_ARB_WDOG_EN to add a stall watchdog. It releases
// a lock whose holder has stopped requesting for WDOG_CYCLES cycles.
//
// Parameters
//   NUM_REQ      number of requesters (0=N, 1=S, 2=E, 3=W, 4=L)
//   REQ_MASK     bit i = 0 marks requester i as absent; its req/tail are ignored
//   WDOG_CYCLES  stall limit, used only with RR_ARB_WDOG_EN
//
// Ports
//   clk            clock
//   rst            synchronous active-low reset
//   req_i          requester i has a flit for this output at its FIFO head
//   tail_i         head flit of requester i is the last flit of its packet
//   port_full_i    output port has no credit this cycle
//   port_select_o  crossbar select, requester index or 3'd7 when idle
//   port_enable_o  write the crossbar flit into the output port
//   port_remove_o  one-hot pop of the granted input FIFO
//   busy_o         a packet lock is held
//   wdog_o         one-cycle pulse when the watchdog releases a lock
// -----------------------------------------------------------------------------
module rr_output_arbiter #(
  parameter int                 NUM_REQ     = 5,
  parameter logic [NUM_REQ-1:0] REQ_MASK    = {NUM_REQ{1'b1}},
  parameter int                 WDOG_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] tail_i,
  input  logic               port_full_i,
  output logic [2:0]         port_select_o,
  output logic               port_enable_o,
  output logic [NUM_REQ-1:0] port_remove_o,
  output logic               busy_o,
  output logic               wdog_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         gnt_id_q, gnt_id_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] ereq_s;
  logic [NUM_REQ-1:0] etail_s;
  logic [NUM_REQ-1:0] gnt_oh_s;
  logic               holder_req_s;
  logic               holder_tail_s;
  logic               xfer_s;

  // Round-robin pick: the first set bit at ptr+1, ptr+2, ... modulo NUM_REQ.
  // The scan runs from the farthest offset to the nearest so that the nearest
  // set bit is the last one written and so wins.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [2:0]         ptr);
    logic [2:0] win;
    logic [2:0] idx;
    win = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = 3'((int'(ptr) + k) % NUM_REQ);
      win = req[idx] ? idx : win;
    end
    return win;
  endfunction

  // Mask out absent requesters and decode the holder's request/tail
  always_comb begin
    ereq_s        = req_i & REQ_MASK;
    etail_s       = tail_i & REQ_MASK;
    gnt_oh_s      = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
    holder_req_s  = |(ereq_s & gnt_oh_s);
    holder_tail_s = |(etail_s & gnt_oh_s);
    // Gate on rst so that a reset cycle can never pop a FIFO.
    xfer_s        = (state_q == LOCKED) & holder_req_s & ~port_full_i & rst;
  end

`ifdef RR_ARB_WDOG_EN
  localparam logic [4:0] WDOG_LIMIT = 5'(WDOG_CYCLES);

  logic [4:0] stall_cnt_q, stall_cnt_d;
  logic       wdog_q, wdog_d;
`else
  // The watchdog is absent, so only the parameter width is exercised here.
  logic [4:0] unused_wdog_limit;
  assign unused_wdog_limit = 5'(WDOG_CYCLES);
`endif

  // Next-state logic: arbitration in IDLE, lock hold and release in LOCKED
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
`ifdef RR_ARB_WDOG_EN
    wdog_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|ereq_s) begin
          state_d  = LOCKED;
          gnt_id_d = rr_pick(ereq_s, rr_ptr_q);
        end else begin
          state_d  = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && holder_tail_s) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_id_q;
        end
`ifdef RR_ARB_WDOG_EN
        else if (!holder_req_s && (stall_cnt_q == (WDOG_LIMIT - 5'd1))) begin
          // This is the stall cycle that makes the count reach the limit.
          state_d  = IDLE;
          rr_ptr_d = gnt_id_q;
          wdog_d   = 1'b1;
        end
`endif
        else begin
          state_d  = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef RR_ARB_WDOG_EN
  // Stall counter: count holder bubbles, hold on credit stalls, else clear
  always_comb begin
    stall_cnt_d = 5'd0;
    if ((state_q == LOCKED) && !holder_req_s && (state_d == LOCKED)) begin
      stall_cnt_d = stall_cnt_q + 5'd1;
    end else if ((state_q == LOCKED) && holder_req_s && !xfer_s) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = 5'd0;
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 5'd0;
      wdog_q      <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wdog_q      <= wdog_d;
    end
  end

  assign wdog_o = wdog_q;
`else
  assign wdog_o = 1'b0;
`endif

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_id_q <= 3'd0;
      rr_ptr_q <= 3'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output decode: select/busy come from state, enable/pop follow xfer
  always_comb begin
    busy_o        = (state_q == LOCKED);
    port_select_o = (state_q == LOCKED) ? gnt_id_q : 3'd7;
    port_enable_o = xfer_s;
    port_remove_o = xfer_s ? gnt_oh_s : {NUM_REQ{1'b0}};
  end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter. A table of per-cycle vectors covers
// reset, single-flit grants, round-robin order, a multi-flit packet with
// bubbles and credit stalls, and reset during a packet. Hand-written sequences
// cover a masked requester (second instance) and the watchdog.
module tb_rr_output_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] req = 5'd0, tail = 5'd0;
  logic       full = 1'b0;
  logic [2:0] sel;
  logic       en, busy, wdog;
  logic [4:0] rem;

  logic [4:0] m_req = 5'd0, m_tail = 5'd0;
  logic [2:0] m_sel;
  logic       m_en, m_busy, m_wdog;
  logic [4:0] m_rem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_output_arbiter #(.NUM_REQ(5), .REQ_MASK(5'b11111), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_i(req), .tail_i(tail), .port_full_i(full),
    .port_select_o(sel), .port_enable_o(en), .port_remove_o(rem),
    .busy_o(busy), .wdog_o(wdog));

  rr_output_arbiter #(.NUM_REQ(5), .REQ_MASK(5'b11011), .WDOG_CYCLES(16)) dut_m (
    .clk(clk), .rst(rst), .req_i(m_req), .tail_i(m_tail), .port_full_i(1'b0),
    .port_select_o(m_sel), .port_enable_o(m_en), .port_remove_o(m_rem),
    .busy_o(m_busy), .wdog_o(m_wdog));

  typedef struct {
    logic       r;
    logic [4:0] rq;
    logic [4:0] tl;
    logic       f;
    logic       chk_sel;
    logic [2:0] sel;
    logic       en;
    logic [4:0] rem;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [4:0] rq, logic [4:0] tl, logic f,
                              logic cs, logic [2:0] s, logic e, logic [4:0] rm, logic b);
    vec_t v;
    v.r = r; v.rq = rq; v.tl = tl; v.f = f; v.chk_sel = cs;
    v.sel = s; v.en = e; v.rem = rm; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the main DUT after the falling edge, then check it
  task automatic step(input string nm, input logic r, input logic [4:0] rq, input logic [4:0] tl,
                      input logic f, input logic cs, input logic [2:0] s, input logic e,
                      input logic [4:0] rm, input logic b, input logic w);
    @(negedge clk);
    rst = r; req = rq; tail = tl; full = f;
    #1;
    if (cs) begin
      chk({nm, " sel"}, 8'(sel), 8'(s));
      chk({nm, " busy"}, 8'(busy), 8'(b));
    end
    chk({nm, " en"}, 8'(en), 8'(e));
    chk({nm, " rem"}, 8'(rem), 8'(rm));
    chk({nm, " wdog"}, 8'(wdog), 8'(w));
  endtask

  // Same as step but on the masked instance
  task automatic mstep(input string nm, input logic [4:0] rq, input logic [4:0] tl,
                       input logic [2:0] s, input logic e, input logic [4:0] rm, input logic b);
    @(negedge clk);
    m_req = rq; m_tail = tl;
    #1;
    chk({nm, " sel"}, 8'(m_sel), 8'(s));
    chk({nm, " en"}, 8'(m_en), 8'(e));
    chk({nm, " rem"}, 8'(m_rem), 8'(rm));
    chk({nm, " busy"}, 8'(m_busy), 8'(b));
  endtask

  initial begin
    logic [4:0] oh;
    // reset
    vecs.push_back(mk(0, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(0, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    // single-flit packet from port 0
    vecs.push_back(mk(1, 5'h01, 5'h01, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h01, 5'h01, 0, 1, 3'd0, 1, 5'h01, 1));
    vecs.push_back(mk(1, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    // all ports, 1-flit packets: grant order 0,1,2,3,4,0
    vecs.push_back(mk(0, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    for (int g = 0; g < 6; g++) begin
      oh = 5'd1 << (g % 5);
      vecs.push_back(mk(1, 5'h1F, 5'h1F, 0, 1, 3'd7, 0, 5'h00, 0));
      vecs.push_back(mk(1, 5'h1F, 5'h1F, 0, 1, 3'(g % 5), 1, oh, 1));
    end
    // port 3 four-flit packet, port 1 waiting, bubble and credit stalls
    vecs.push_back(mk(1, 5'h08, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h0A, 5'h02, 0, 1, 3'd3, 1, 5'h08, 1));
    vecs.push_back(mk(1, 5'h0A, 5'h02, 0, 1, 3'd3, 1, 5'h08, 1));
    vecs.push_back(mk(1, 5'h02, 5'h02, 0, 1, 3'd3, 0, 5'h00, 1));
    vecs.push_back(mk(1, 5'h0A, 5'h02, 1, 1, 3'd3, 0, 5'h00, 1));
    vecs.push_back(mk(1, 5'h0A, 5'h0A, 1, 1, 3'd3, 0, 5'h00, 1));
    vecs.push_back(mk(1, 5'h0A, 5'h02, 0, 1, 3'd3, 1, 5'h08, 1));
    vecs.push_back(mk(1, 5'h0A, 5'h0A, 0, 1, 3'd3, 1, 5'h08, 1));
    // after tail on 3, scan order 4,0,1,.. picks port 1
    vecs.push_back(mk(1, 5'h0A, 5'h0A, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h0A, 5'h0A, 0, 1, 3'd1, 1, 5'h02, 1));
    vecs.push_back(mk(1, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    // reset mid-packet drops the lock; port 0 wins first afterwards
    vecs.push_back(mk(0, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h04, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h04, 5'h00, 0, 1, 3'd2, 1, 5'h04, 1));
    vecs.push_back(mk(0, 5'h04, 5'h00, 0, 0, 3'd0, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h05, 5'h05, 0, 1, 3'd7, 0, 5'h00, 0));
    vecs.push_back(mk(1, 5'h05, 5'h05, 0, 1, 3'd0, 1, 5'h01, 1));
    vecs.push_back(mk(1, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0));

    foreach (vecs[i]) begin
      step($sformatf("row%0d", i), vecs[i].r, vecs[i].rq, vecs[i].tl, vecs[i].f,
           vecs[i].chk_sel, vecs[i].sel, vecs[i].en, vecs[i].rem, vecs[i].busy, 1'b0);
    end

    // masked port 2 never granted; port 0 on the same instance still works
    for (int i = 0; i < 6; i++) begin
      mstep($sformatf("mask%0d", i), 5'h04, 5'h04, 3'd7, 0, 5'h00, 0);
    end
    mstep("mask_arb", 5'h05, 5'h05, 3'd7, 0, 5'h00, 0);
    mstep("mask_gnt", 5'h05, 5'h05, 3'd0, 1, 5'h01, 1);
    mstep("mask_end", 5'h00, 5'h00, 3'd7, 0, 5'h00, 0);

    // port 2 sends a head without a tail, then its request drops; port 3 waits
    step("wd_rst", 0, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0, 0);
    step("wd_arb", 1, 5'h04, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0, 0);
    step("wd_head", 1, 5'h0C, 5'h00, 0, 1, 3'd2, 1, 5'h04, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("wd_stall%0d", i), 1, 5'h08, 5'h08, 0, 1, 3'd2, 0, 5'h00, 1, 0);
    end
`ifdef RR_ARB_WDOG_EN
    step("wd_fire", 1, 5'h08, 5'h08, 0, 1, 3'd7, 0, 5'h00, 0, 1);
    step("wd_next", 1, 5'h08, 5'h08, 0, 1, 3'd3, 1, 5'h08, 1, 0);
    step("wd_done", 1, 5'h00, 5'h00, 0, 1, 3'd7, 0, 5'h00, 0, 0);
`else
    for (int i = 0; i < 4; i++) begin
      step($sformatf("wd_hold%0d", i), 1, 5'h08, 5'h08, 0, 1, 3'd2, 0, 5'h00, 1, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
